data_ram_ws: RTL

//  Word-organised data memory with per-byte lane select and a programmable wait-state

---
 rtl/data_ram_ws.sv | 113 +++++++++++
 1 files changed

// File: rtl/data_ram_ws.sv
// Word-organised data RAM with byte-lane writes and a programmable wait-state handshake.
// A request is held by the MEM stage while o_stall is high; data commits on entry to DONE.
module data_ram_ws #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_readEnable,
  input  logic        i_writeEnable,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_storeData,
  output logic [31:0] o_loadData,
  output logic        o_stall,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [3:0]            cnt_r;
  logic [3:0]            cnt_nxt_s;
  logic                  req_s;
  logic                  commit_s;
  logic                  commit_en_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [31:0]           load_data_r;
  logic [31:0]           mem_r [2**DEPTH_LOG2];

  assign req_s       = i_readEnable | i_writeEnable;
  assign idx_s       = i_addr[DEPTH_LOG2+1:2];
  assign commit_en_s = commit_s & ~rst;

  // Next-state, wait counter and commit strobe
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_INIT;
          end else begin
            state_nxt_s = ST_DONE;
            commit_s    = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Dropping the request mid-wait aborts without touching the array
        if (!req_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_nxt_s = ST_DONE;
          commit_s    = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and registered load data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      load_data_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (commit_en_s) begin
        load_data_r <= mem_r[idx_s];
      end
    end
  end

  // Byte-lane array write; the read above sees the pre-write word
  always_ff @(posedge clk) begin
    if (commit_en_s && i_writeEnable) begin
      for (int k = 0; k < 4; k++) begin
        if (i_sel[k]) begin
          mem_r[idx_s][8*k +: 8] <= i_storeData[8*k +: 8];
        end
      end
    end
  end

  assign o_loadData = load_data_r;
  assign o_stall    = req_s & (state_r != ST_DONE) & ~rst;
  assign o_busy     = (state_r != ST_IDLE);

endmodule
